rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single synchronous-read instruction ROM between two requesters: the instruction-fetch path (IF) and the load/store unit (LSU, for constant and data reads in ROM space).
- Arbitrates per cycle and routes each 1-cycle-latency read response back to its owner.
- Raises hold_flag_o to stall the PC/fetch pipeline when LSU wins.
- Drops in-flight fetch responses on a jump.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 4, max consecutive IF denials before IF is forced a grant (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- if_req_i  input  1  IF read request.
- if_addr_i  input  AW  IF read address.
- lsu_req_i  input  1  LSU read request.
- lsu_addr_i  input  AW  LSU read address.
- jump_en_i  input  1  branch/jump taken; flush pending IF response.
- rom_re_o  output  1  ROM read enable.
- rom_addr_o  output  AW  ROM address.
- rom_data_i  input  DW  ROM data; valid the cycle after rom_re_o.
- if_gnt_o  output  1  IF request accepted this cycle.
- if_rvalid_o  output  1  IF response valid.
- if_rdata_o  output  DW  IF response data.
- lsu_gnt_o  output  1  LSU request accepted this cycle.
- lsu_rvalid_o  output  1  LSU response valid.
- lsu_rdata_o  output  DW  LSU response data.
- hold_flag_o  output  1  stall request to fetch pipeline.

Behaviour:
- Reset, while rst=0:
  - Registered outputs are 0: if_rvalid_o, lsu_rvalid_o, rom_addr_o.
  - State is IDLE and the starve counter is 0.
  - Combinational outputs evaluate to 0 with no requests.
- Grant logic is combinational in the request cycle:
  - LSU has priority.
  - IF wins only if lsu_req_i=0, or the starve count equals STARVE_MAX.
  - At most one grant per cycle.
  - rom_re_o = if_gnt_o | lsu_gnt_o.
  - rom_addr_o is the winner's address, registered into the ROM address path on the same edge (ROM samples on that edge).
  - When idle, rom_addr_o holds its last value.
- Starve counter (4-bit, saturating at STARVE_MAX):
  - Increments each cycle with if_req_i=1 and if_gnt_o=0.
  - Clears on an IF grant or when if_req_i=0.
- Owner state, tracking the read in flight:
  - States: IDLE, IF_RD, LSU_RD.
  - Next state is IF_RD on an IF grant, LSU_RD on an LSU grant, else IDLE.
  - Back-to-back grants are allowed (fully pipelined; one request per cycle).
- Response routing, the cycle after a grant:
  - The owner's rvalid is 1 and its rdata = rom_data_i.
  - The non-owner's rvalid is 0 and its rdata holds its last value.
- Jump flush:
  - If jump_en_i=1 in the cycle an IF response is due (state IF_RD), if_rvalid_o is forced 0 and the response is discarded.
  - If jump_en_i=1 in the same cycle as an IF grant, that grant proceeds to ROM but its response is discarded next cycle.
  - LSU responses are never flushed.
- hold_flag_o = if_req_i & lsu_gnt_o (combinational). It is deasserted in the cycle IF is forced through by starvation.
- Simultaneous events:
  - Both requesters plus starve==STARVE_MAX: IF is granted, LSU is denied, lsu_gnt_o=0.
  - LSU must hold its request until granted; no request queuing.
- Reset asserted mid-read: the in-flight response is lost; no rvalid is produced after release.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- When defined:
  - Adds 32-bit outputs if_gnt_cnt_o, lsu_gnt_cnt_o and starve_evt_cnt_o.
  - Grant counters increment on each respective grant.
  - The event counter increments on each forced IF grant.
  - All wrap at 2^32 and reset to 0.
- When undefined: no such ports or counters; behaviour otherwise identical.

Decomposition:
- Shared package/defines file holds:
  - Owner-state encodings: IDLE=2'd0, IF_RD=2'd1, LSU_RD=2'd2.
  - Default STARVE_MAX.
  - INST_NOP, which already lives in the common instruction defines.
- One natural sub-module, rom_arb_starve_cnt: the saturating starvation counter with clear and force-grant flag.

Test Plan:
- Reset with both requests high (rst=0) → all grants, rvalid and rom_re_o are 0. Release → LSU is granted first cycle, lsu_rvalid_o=1 one cycle later with data at lsu_addr_i.
- IF only, addresses 0x0, 0x4, 0x8 on consecutive cycles → if_gnt_o=1 each cycle, if_rvalid_o=1 on cycles 1..3 with matching ROM words, hold_flag_o=0 throughout.
- Both requests held continuously, STARVE_MAX=4 → LSU granted 4 cycles with hold_flag_o=1, IF granted on the 5th, pattern repeats.
- IF granted at 0x10, jump_en_i=1 next cycle → if_rvalid_o=0 that cycle, no data delivered.
- Alternating LSU/IF grants back-to-back → responses routed to the correct owner every cycle, non-owner rdata unchanged.
- Reset asserted during an LSU_RD cycle → lsu_rvalid_o=0 immediately and after release.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
package rom_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      LSU_RD = 2'd2
   } owner_e;

   localparam int STARVE_MAX_DEF = 4;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
      return (val >= lim) ? lim : val + 4'd1;
   endfunction

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating count of consecutive IF denials; flags a forced IF grant when
// the count reaches STARVE_MAX (valid range 1..15).
module rom_arb_starve_cnt
   import rom_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req_i,
   input  logic if_gnt_i,
   output logic force_o
);

   localparam logic [3:0] LIM = 4'(STARVE_MAX);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!if_req_i || if_gnt_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = sat_inc4(cnt_q, LIM);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign force_o = (cnt_q == LIM);

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for the synchronous instruction ROM (IF vs LSU).
// Define ROM_ARB_STATS_EN to add grant / starvation-event counters.
//
// state  | meaning
// IDLE   | no ROM read in flight
// IF_RD  | ROM word arriving this cycle belongs to instruction fetch
// LSU_RD | ROM word arriving this cycle belongs to the load/store unit
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   input  logic          lsu_req_i,
   input  logic [AW-1:0] lsu_addr_i,
   input  logic          jump_en_i,
   output logic          rom_re_o,
   output logic [AW-1:0] rom_addr_o,
   input  logic [DW-1:0] rom_data_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [DW-1:0] if_rdata_o,
   output logic          lsu_gnt_o,
   output logic          lsu_rvalid_o,
   output logic [DW-1:0] lsu_rdata_o,
   output logic          hold_flag_o
`ifdef ROM_ARB_STATS_EN
   ,
   output logic [31:0]   if_gnt_cnt_o,
   output logic [31:0]   lsu_gnt_cnt_o,
   output logic [31:0]   starve_evt_cnt_o
`endif
);

   owner_e        state_q, state_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic          if_drop_q, if_drop_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] lsu_rdata_q, lsu_rdata_d;
   logic          force_if;
   logic          if_gnt;
   logic          lsu_gnt;
   logic          if_rvalid;
   logic          lsu_rvalid;

   rom_arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .if_req_i (if_req_i),
      .if_gnt_i (if_gnt),
      .force_o  (force_if)
   );

   // Grants are gated by rst so nothing reaches the ROM while held in reset.
   always_comb begin
      if_gnt      = rst & if_req_i & (~lsu_req_i | force_if);
      lsu_gnt     = rst & lsu_req_i & ~if_gnt;
      rom_addr_d  = rom_addr_q;
      if (lsu_gnt) begin
         rom_addr_d = lsu_addr_i;
      end else if (if_gnt) begin
         rom_addr_d = if_addr_i;
      end

      state_d = IDLE;
      if (if_gnt) begin
         state_d = IF_RD;
      end else if (lsu_gnt) begin
         state_d = LSU_RD;
      end

      // A jump in the grant cycle still lets the read go out; only the reply is dropped.
      if_drop_d   = if_gnt & jump_en_i;
      if_rvalid   = (state_q == IF_RD) & ~if_drop_q & ~jump_en_i;
      lsu_rvalid  = (state_q == LSU_RD);
      if_rdata_d  = if_rvalid  ? rom_data_i : if_rdata_q;
      lsu_rdata_d = lsu_rvalid ? rom_data_i : lsu_rdata_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         rom_addr_q  <= '0;
         if_drop_q   <= 1'b0;
         if_rdata_q  <= '0;
         lsu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rom_addr_q  <= rom_addr_d;
         if_drop_q   <= if_drop_d;
         if_rdata_q  <= if_rdata_d;
         lsu_rdata_q <= lsu_rdata_d;
      end
   end

   assign if_gnt_o     = if_gnt;
   assign lsu_gnt_o    = lsu_gnt;
   assign rom_re_o     = if_gnt | lsu_gnt;
   assign rom_addr_o   = rom_addr_q;
   assign if_rvalid_o  = if_rvalid;
   assign if_rdata_o   = if_rdata_d;
   assign lsu_rvalid_o = lsu_rvalid;
   assign lsu_rdata_o  = lsu_rdata_d;
   assign hold_flag_o  = if_req_i & lsu_gnt;

`ifdef ROM_ARB_STATS_EN
   logic [31:0] if_cnt_q, if_cnt_d;
   logic [31:0] lsu_cnt_q, lsu_cnt_d;
   logic [31:0] evt_cnt_q, evt_cnt_d;

   // A forced grant is one IF only got because the starvation limit overrode LSU.
   always_comb begin
      if_cnt_d  = if_cnt_q  + {31'd0, if_gnt};
      lsu_cnt_d = lsu_cnt_q + {31'd0, lsu_gnt};
      evt_cnt_d = evt_cnt_q + {31'd0, if_gnt & lsu_req_i & force_if};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_cnt_q  <= '0;
         lsu_cnt_q <= '0;
         evt_cnt_q <= '0;
      end else begin
         if_cnt_q  <= if_cnt_d;
         lsu_cnt_q <= lsu_cnt_d;
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign if_gnt_cnt_o     = if_cnt_q;
   assign lsu_gnt_cnt_o    = lsu_cnt_q;
   assign starve_evt_cnt_o = evt_cnt_q;
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed, table-driven bench for rom_arbiter with a behavioural ROM.
module tb_rom_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        lsu_req_i;
   logic [31:0] lsu_addr_i;
   logic        jump_en_i;
   logic        rom_re_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        lsu_gnt_o;
   logic        lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        hold_flag_o;
`ifdef ROM_ARB_STATS_EN
   logic [31:0] if_gnt_cnt_o;
   logic [31:0] lsu_gnt_cnt_o;
   logic [31:0] starve_evt_cnt_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   rom_arbiter #(
      .AW         (32),
      .DW         (32),
      .STARVE_MAX (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_i     (if_req_i),
      .if_addr_i    (if_addr_i),
      .lsu_req_i    (lsu_req_i),
      .lsu_addr_i   (lsu_addr_i),
      .jump_en_i    (jump_en_i),
      .rom_re_o     (rom_re_o),
      .rom_addr_o   (rom_addr_o),
      .rom_data_i   (rom_data_i),
      .if_gnt_o     (if_gnt_o),
      .if_rvalid_o  (if_rvalid_o),
      .if_rdata_o   (if_rdata_o),
      .lsu_gnt_o    (lsu_gnt_o),
      .lsu_rvalid_o (lsu_rvalid_o),
      .lsu_rdata_o  (lsu_rdata_o),
      .hold_flag_o  (hold_flag_o)
`ifdef ROM_ARB_STATS_EN
      ,
      .if_gnt_cnt_o     (if_gnt_cnt_o),
      .lsu_gnt_cnt_o    (lsu_gnt_cnt_o),
      .starve_evt_cnt_o (starve_evt_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: the word at address a is a ^ 0x5A5A0000.
   function automatic logic [31:0] w(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // rom_addr_o is the ROM's registered address, so the word is available combinationally from it.
   assign rom_data_i = w(rom_addr_o);

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        lsu_req;
      logic [31:0] lsu_addr;
      logic        jump;
      logic        e_if_gnt;
      logic        e_lsu_gnt;
      logic        e_hold;
      logic [31:0] e_rom_addr;
      logic        e_if_rv;
      logic [31:0] e_if_rd;
      logic        e_lsu_rv;
      logic [31:0] e_lsu_rd;
   } vec_t;

   vec_t tv[20];

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr,
                               input logic [31:0] la, input logic j, input logic eig,
                               input logic elg, input logic eh, input logic [31:0] era,
                               input logic eirv, input logic [31:0] eird,
                               input logic elrv, input logic [31:0] elrd);
      vec_t v;
      v.if_req = ir;    v.if_addr = ia;    v.lsu_req = lr;   v.lsu_addr = la;
      v.jump = j;       v.e_if_gnt = eig;  v.e_lsu_gnt = elg; v.e_hold = eh;
      v.e_rom_addr = era;
      v.e_if_rv = eirv; v.e_if_rd = eird;  v.e_lsu_rv = elrv; v.e_lsu_rd = elrd;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   initial begin
      // reset with both requesters active, then starvation, IF stream, jump flushes, alternation
      tv[0]  = mk(1, 32'h0,   1, 32'h100, 0, 0, 1, 1, 32'h0,   0, 32'h0,     0, 32'h0);
      tv[1]  = mk(1, 32'h0,   1, 32'h104, 0, 0, 1, 1, 32'h100, 0, 32'h0,     1, w(32'h100));
      tv[2]  = mk(1, 32'h0,   1, 32'h108, 0, 0, 1, 1, 32'h104, 0, 32'h0,     1, w(32'h104));
      tv[3]  = mk(1, 32'h0,   1, 32'h10C, 0, 0, 1, 1, 32'h108, 0, 32'h0,     1, w(32'h108));
      tv[4]  = mk(1, 32'h0,   1, 32'h110, 0, 1, 0, 0, 32'h10C, 0, 32'h0,     1, w(32'h10C));
      tv[5]  = mk(1, 32'h4,   1, 32'h110, 0, 0, 1, 1, 32'h0,   1, w(32'h0),  0, w(32'h10C));
      tv[6]  = mk(1, 32'h4,   0, 32'h110, 0, 1, 0, 0, 32'h110, 0, w(32'h0),  1, w(32'h110));
      tv[7]  = mk(1, 32'h8,   0, 32'h0,   0, 1, 0, 0, 32'h4,   1, w(32'h4),  0, w(32'h110));
      tv[8]  = mk(1, 32'hC,   0, 32'h0,   0, 1, 0, 0, 32'h8,   1, w(32'h8),  0, w(32'h110));
      tv[9]  = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'hC,   1, w(32'hC),  0, w(32'h110));
      tv[10] = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'hC,   0, w(32'hC),  0, w(32'h110));
      tv[11] = mk(1, 32'h10,  0, 32'h0,   0, 1, 0, 0, 32'hC,   0, w(32'hC),  0, w(32'h110));
      tv[12] = mk(0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h10,  0, w(32'hC),  0, w(32'h110));
      tv[13] = mk(1, 32'h14,  0, 32'h0,   1, 1, 0, 0, 32'h10,  0, w(32'hC),  0, w(32'h110));
      tv[14] = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h14,  0, w(32'hC),  0, w(32'h110));
      tv[15] = mk(0, 32'h0,   1, 32'h200, 0, 0, 1, 0, 32'h14,  0, w(32'hC),  0, w(32'h110));
      tv[16] = mk(1, 32'h20,  0, 32'h0,   0, 1, 0, 0, 32'h200, 0, w(32'hC),  1, w(32'h200));
      tv[17] = mk(0, 32'h0,   1, 32'h204, 0, 0, 1, 0, 32'h20,  1, w(32'h20), 0, w(32'h200));
      tv[18] = mk(1, 32'h24,  0, 32'h0,   1, 1, 0, 0, 32'h204, 0, w(32'h20), 1, w(32'h204));
      tv[19] = mk(0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h24,  0, w(32'h20), 0, w(32'h204));

      rst        = 1'b0;
      if_req_i   = 1'b1;
      if_addr_i  = 32'h0;
      lsu_req_i  = 1'b1;
      lsu_addr_i = 32'h100;
      jump_en_i  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_if_gnt",     0, {31'd0, if_gnt_o},     32'd0);
      chk("rst_lsu_gnt",    0, {31'd0, lsu_gnt_o},    32'd0);
      chk("rst_rom_re",     0, {31'd0, rom_re_o},     32'd0);
      chk("rst_if_rvalid",  0, {31'd0, if_rvalid_o},  32'd0);
      chk("rst_lsu_rvalid", 0, {31'd0, lsu_rvalid_o}, 32'd0);
      chk("rst_rom_addr",   0, rom_addr_o,            32'd0);
      chk("rst_hold",       0, {31'd0, hold_flag_o},  32'd0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         rst        = 1'b1;
         if_req_i   = tv[i].if_req;
         if_addr_i  = tv[i].if_addr;
         lsu_req_i  = tv[i].lsu_req;
         lsu_addr_i = tv[i].lsu_addr;
         jump_en_i  = tv[i].jump;
         #1;
         chk("if_gnt",     i, {31'd0, if_gnt_o},     {31'd0, tv[i].e_if_gnt});
         chk("lsu_gnt",    i, {31'd0, lsu_gnt_o},    {31'd0, tv[i].e_lsu_gnt});
         chk("rom_re",     i, {31'd0, rom_re_o},     {31'd0, tv[i].e_if_gnt | tv[i].e_lsu_gnt});
         chk("hold",       i, {31'd0, hold_flag_o},  {31'd0, tv[i].e_hold});
         chk("rom_addr",   i, rom_addr_o,            tv[i].e_rom_addr);
         chk("if_rvalid",  i, {31'd0, if_rvalid_o},  {31'd0, tv[i].e_if_rv});
         chk("if_rdata",   i, if_rdata_o,            tv[i].e_if_rd);
         chk("lsu_rvalid", i, {31'd0, lsu_rvalid_o}, {31'd0, tv[i].e_lsu_rv});
         chk("lsu_rdata",  i, lsu_rdata_o,           tv[i].e_lsu_rd);
      end

      // Reset asserted while an LSU response is due: it must never appear.
      @(negedge clk);
      if_req_i   = 1'b0;
      lsu_req_i  = 1'b1;
      lsu_addr_i = 32'h300;
      jump_en_i  = 1'b0;
      #1;
      chk("mid_lsu_gnt", 0, {31'd0, lsu_gnt_o}, 32'd1);
      @(negedge clk);
      lsu_req_i = 1'b0;
      rst       = 1'b0;
      #1;
      chk("mid_rst_lsu_rvalid", 0, {31'd0, lsu_rvalid_o}, 32'd0);
      chk("mid_rst_rom_addr",   0, rom_addr_o,            32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_lsu_rvalid", 0, {31'd0, lsu_rvalid_o}, 32'd0);
      chk("post_rst_if_rvalid",  0, {31'd0, if_rvalid_o},  32'd0);
      @(negedge clk);
      #1;
      chk("post_rst_lsu_rvalid", 1, {31'd0, lsu_rvalid_o}, 32'd0);
      chk("post_rst_rom_re",     1, {31'd0, rom_re_o},     32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
